// File: rtl/mem_access_stage_pkg.sv
// Shared types for the stage-4 memory access unit: FSM states, writeback
// select encoding and the default widths.
package mem_access_stage_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CTR_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wbsel_e;

  // Jump link value beats load data, which beats the ALU result.
  function automatic wbsel_e wb_select(input logic jump, input logic memtoreg);
    if (jump)          return WB_LINK;
    else if (memtoreg) return WB_LOAD;
    else               return WB_ALU;
  endfunction

endpackage

// File: rtl/mem_access_stage_timeout.sv
// 8-bit access watchdog: cleared when a request is issued, counts while the
// access is outstanding, flags the increment that reaches TIMEOUT.
module mem_timeout_ctr
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CTR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= r_count + 1'b1;
  end

  // Asserted on the cycle whose increment brings the count to TIMEOUT.
  assign o_tc = i_en & (r_count == CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Stage-4 memory access: issues ready/valid data-memory accesses, freezes the
// stage-3/4 register while an access is outstanding, registers writeback results.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid34,
  input  logic [31:0]       addp4out34,
  input  logic [31:0]       alu_out34,
  input  logic [31:0]       read_data234,
  input  logic [4:0]        write_reg34,
  input  logic              memwrite34,
  input  logic              mem_read34,
  input  logic              wr_en34,
  input  logic              memtoreg34,
  input  logic              jump34,
  output logic              stall34,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid45,
  output logic [31:0]       wb_data45,
  output logic [4:0]        wb_reg45,
  output logic              wb_en45,
  output logic              bus_err
);

  state_e            r_state, w_state_nxt;
  logic              r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic [31:0]       r_load_data;
  logic              r_abort;
  logic              r_bus_err;
  logic              r_wb_valid_p1, r_wb_en_p1;
  logic [31:0]       r_wb_data_p1;
  logic [4:0]        r_wb_reg_p1;

  logic w_memop, w_misalign, w_conflict, w_bad, w_clean;
  logic w_stall, w_issue, w_ctr_en, w_tc, w_result;
  logic w_abort_set, w_capture, w_err_now, w_err_inst;
  logic [31:0] w_load, w_wb_data;

  assign w_memop    = valid34 & (mem_read34 | memwrite34);
  assign w_misalign = w_memop & (alu_out34[1:0] != 2'b00);
  assign w_conflict = w_memop & mem_read34 & memwrite34;
  assign w_bad      = w_misalign | w_conflict;
  assign w_clean    = w_memop & ~w_bad;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_issue),
    .i_en  (w_ctr_en),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_issue     = 1'b0;
    w_ctr_en    = 1'b0;
    w_result    = 1'b0;
    w_abort_set = 1'b0;
    w_capture   = 1'b0;
    w_err_now   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_clean) begin
          w_stall     = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_result  = 1'b1;
          w_err_now = w_bad;
        end
      end
      S_REQ: begin
        w_stall  = 1'b1;
        w_ctr_en = 1'b1;
        if (dmem_ready) begin
          w_state_nxt = r_dmem_we ? S_DONE : S_WAIT;
        end else if (w_tc) begin
          w_abort_set = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        w_stall  = 1'b1;
        w_ctr_en = 1'b1;
        if (dmem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_tc) begin
          w_abort_set = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_result    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Load data only means something for the access that just completed.
  assign w_load     = (r_state == S_DONE) ? r_load_data : 32'h0;
  assign w_err_inst = w_err_now | ((r_state == S_DONE) & r_abort);

  always_comb begin
    w_wb_data = alu_out34;
    case (wb_select(jump34, memtoreg34))
      WB_LINK: w_wb_data = addp4out34;
      WB_LOAD: w_wb_data = w_load;
      default: w_wb_data = alu_out34;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture: held stable from REQ entry until the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_load_data  <= '0;
      r_abort      <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_dmem_we    <= memwrite34;
        r_dmem_addr  <= {alu_out34[ADDR_W-1:2], 2'b00};
        r_dmem_wdata <= DATA_W'(read_data234);
        r_load_data  <= '0;
        r_abort      <= 1'b0;
      end else if (w_capture) begin
        r_load_data  <= 32'(dmem_rdata);
      end else if (w_abort_set) begin
        r_load_data  <= '0;
        r_abort      <= 1'b1;
      end
      if (w_err_now | w_abort_set) r_bus_err <= 1'b1;
    end
  end

  // Stage 4 -> 5 boundary: writeback result register, bubble while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid_p1 <= 1'b0;
      r_wb_en_p1    <= 1'b0;
      r_wb_data_p1  <= '0;
      r_wb_reg_p1   <= '0;
    end else if (w_result) begin
      r_wb_valid_p1 <= valid34;
      r_wb_en_p1    <= wr_en34 & valid34 & ~memwrite34 & ~w_err_inst;
      r_wb_data_p1  <= w_wb_data;
      r_wb_reg_p1   <= write_reg34;
    end else begin
      r_wb_valid_p1 <= 1'b0;
      r_wb_en_p1    <= 1'b0;
    end
  end

  assign stall34    = w_stall;
  assign dmem_req   = (r_state == S_REQ);
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign wb_valid45 = r_wb_valid_p1;
  assign wb_data45  = r_wb_data_p1;
  assign wb_reg45   = r_wb_reg_p1;
  assign wb_en45    = r_wb_en_p1;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU, load, store, jump, misalign,
// conflict, timeout and mid-access reset scenarios.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid34;
  logic [31:0] addp4out34, alu_out34, read_data234;
  logic [4:0]  write_reg34;
  logic        memwrite34, mem_read34, wr_en34, memtoreg34, jump34;
  logic        stall34, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid45;
  logic [31:0] wb_data45;
  logic [4:0]  wb_reg45;
  logic        wb_en45, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .valid34(valid34), .addp4out34(addp4out34),
    .alu_out34(alu_out34), .read_data234(read_data234), .write_reg34(write_reg34),
    .memwrite34(memwrite34), .mem_read34(mem_read34), .wr_en34(wr_en34),
    .memtoreg34(memtoreg34), .jump34(jump34), .stall34(stall34),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid45(wb_valid45), .wb_data45(wb_data45),
    .wb_reg45(wb_reg45), .wb_en45(wb_en45), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bubble();
    valid34 = 0; addp4out34 = 0; alu_out34 = 0; read_data234 = 0; write_reg34 = 0;
    memwrite34 = 0; mem_read34 = 0; wr_en34 = 0; memtoreg34 = 0; jump34 = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    set_bubble();
    rst_n = 0;
    #1;
    n_tests++; if (stall34 !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall34); end
    n_tests++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req got req=%b we=%b want 0/0", dmem_req, dmem_we); end
    n_tests++; if (wb_valid45 !== 1'b0 || wb_en45 !== 1'b0) begin n_fail++; $display("FAIL reset_wb got v=%b en=%b want 0/0", wb_valid45, wb_en45); end
    n_tests++; if (wb_data45 !== 32'h0 || wb_reg45 !== 5'h0) begin n_fail++; $display("FAIL reset_wbdata got %h/%0d want 0/0", wb_data45, wb_reg45); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_buserr got %b want 0", bus_err); end
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu();
    valid34 = 1; alu_out34 = 32'h1234; wr_en34 = 1; write_reg34 = 5'd3;
    #1;
    n_tests++; if (stall34 !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", stall34); end
    tick();
    set_bubble();
    n_tests++; if (wb_data45 !== 32'h1234 || wb_en45 !== 1'b1 || wb_valid45 !== 1'b1 || wb_reg45 !== 5'd3)
      begin n_fail++; $display("FAIL alu_wb got d=%h en=%b v=%b r=%0d want 1234/1/1/3", wb_data45, wb_en45, wb_valid45, wb_reg45); end
    tick();
    n_tests++; if (wb_valid45 !== 1'b0) begin n_fail++; $display("FAIL bubble_wb got v=%b want 0", wb_valid45); end
  endtask

  task automatic test_load();
    int stalls = 0;
    valid34 = 1; alu_out34 = 32'h40; mem_read34 = 1; memtoreg34 = 1; wr_en34 = 1; write_reg34 = 5'd5;
    #1;
    if (stall34) stalls++;
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_idle_req got %b want 0", dmem_req); end
    tick();
    if (stall34) stalls++;
    n_tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h40 || dmem_we !== 1'b0)
      begin n_fail++; $display("FAIL load_req got req=%b a=%h we=%b want 1/40/0", dmem_req, dmem_addr, dmem_we); end
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    if (stall34) stalls++;
    n_tests++; if (dmem_req !== 1'b0 || wb_valid45 !== 1'b0)
      begin n_fail++; $display("FAIL load_wait got req=%b v=%b want 0/0", dmem_req, wb_valid45); end
    dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_rvalid = 0; dmem_rdata = 0;
    if (stall34) stalls++;
    tick();
    set_bubble();
    n_tests++; if (stalls != 3) begin n_fail++; $display("FAIL load_stall_cycles got %0d want 3", stalls); end
    n_tests++; if (wb_data45 !== 32'hDEADBEEF || wb_en45 !== 1'b1 || wb_valid45 !== 1'b1 || wb_reg45 !== 5'd5)
      begin n_fail++; $display("FAIL load_wb got d=%h en=%b v=%b r=%0d want deadbeef/1/1/5", wb_data45, wb_en45, wb_valid45, wb_reg45); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL load_buserr got %b want 0", bus_err); end
    tick();
  endtask

  task automatic test_store();
    int req_cycles = 0;
    int bad = 0;
    valid34 = 1; alu_out34 = 32'h80; read_data234 = 32'hA5A5A5A5; memwrite34 = 1; wr_en34 = 1; write_reg34 = 5'd7;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (dmem_req) req_cycles++;
      if (dmem_addr !== 32'h80 || dmem_wdata !== 32'hA5A5A5A5 || dmem_we !== 1'b1 || stall34 !== 1'b1) bad++;
      dmem_ready = (i == 2);
      tick();
    end
    dmem_ready = 0;
    n_tests++; if (req_cycles != 3) begin n_fail++; $display("FAIL store_req_cycles got %0d want 3", req_cycles); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL store_stable got %0d bad cycles want 0", bad); end
    n_tests++; if (dmem_req !== 1'b0 || stall34 !== 1'b0)
      begin n_fail++; $display("FAIL store_done got req=%b stall=%b want 0/0", dmem_req, stall34); end
    tick();
    set_bubble();
    n_tests++; if (wb_en45 !== 1'b0 || wb_valid45 !== 1'b1 || wb_data45 !== 32'h80)
      begin n_fail++; $display("FAIL store_wb got en=%b v=%b d=%h want 0/1/80", wb_en45, wb_valid45, wb_data45); end
    tick();
  endtask

  task automatic test_jump();
    valid34 = 1; jump34 = 1; memtoreg34 = 1; addp4out34 = 32'h104; alu_out34 = 32'h55; wr_en34 = 1; write_reg34 = 5'd1;
    tick();
    set_bubble();
    n_tests++; if (wb_data45 !== 32'h104 || wb_en45 !== 1'b1)
      begin n_fail++; $display("FAIL jump_wb got d=%h en=%b want 104/1", wb_data45, wb_en45); end
    tick();
  endtask

  task automatic test_misalign();
    valid34 = 1; alu_out34 = 32'h41; mem_read34 = 1; memtoreg34 = 1; wr_en34 = 1;
    #1;
    n_tests++; if (stall34 !== 1'b0 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL misalign_nostall got stall=%b req=%b want 0/0", stall34, dmem_req); end
    tick();
    set_bubble();
    n_tests++; if (bus_err !== 1'b1 || wb_en45 !== 1'b0 || wb_valid45 !== 1'b1 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL misalign_err got err=%b en=%b v=%b req=%b want 1/0/1/0", bus_err, wb_en45, wb_valid45, dmem_req); end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    rst_n = 0; #2; rst_n = 1;
    tick();
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pre_err got %b want 0", bus_err); end
    valid34 = 1; alu_out34 = 32'h100; mem_read34 = 1; memtoreg34 = 1; wr_en34 = 1;
    tick();
    while (stall34 && n < 400) begin
      n++;
      tick();
    end
    n_tests++; if (n != 255) begin n_fail++; $display("FAIL timeout_cycles got %0d want 255", n); end
    n_tests++; if (bus_err !== 1'b1 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL timeout_err got err=%b req=%b want 1/0", bus_err, dmem_req); end
    tick();
    set_bubble();
    n_tests++; if (wb_en45 !== 1'b0 || wb_valid45 !== 1'b1 || wb_data45 !== 32'h0)
      begin n_fail++; $display("FAIL timeout_wb got en=%b v=%b d=%h want 0/1/0", wb_en45, wb_valid45, wb_data45); end
    tick();
    valid34 = 1; alu_out34 = 32'h200; mem_read34 = 1; memtoreg34 = 1;
    tick();
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL midreset_req got %b want 1", dmem_req); end
    rst_n = 0;
    #1;
    n_tests++; if (dmem_req !== 1'b0 || bus_err !== 1'b0)
      begin n_fail++; $display("FAIL midreset_drop got req=%b err=%b want 0/0", dmem_req, bus_err); end
    set_bubble();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_conflict();
    valid34 = 1; alu_out34 = 32'h10; mem_read34 = 1; memwrite34 = 1; wr_en34 = 1;
    #1;
    n_tests++; if (stall34 !== 1'b0) begin n_fail++; $display("FAIL conflict_stall got %b want 0", stall34); end
    tick();
    set_bubble();
    n_tests++; if (bus_err !== 1'b1 || wb_en45 !== 1'b0 || dmem_req !== 1'b0)
      begin n_fail++; $display("FAIL conflict_err got err=%b en=%b req=%b want 1/0/0", bus_err, wb_en45, dmem_req); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jump();
    test_misalign();
    test_timeout();
    test_conflict();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Stage-4 memory access unit. It sits directly downstream of the stage-3/4 pipeline register and consumes that register's address, store data and control outputs.
- Runs a ready/valid handshake to data memory. Freezes the upstream pipeline while an access is outstanding.
- Produces registered writeback-bound results (data, destination register, write enable) for the final stage.

Parameters:
- ADDR_W, 32, data-memory byte-address width (taken from alu_out34 LSBs)
- DATA_W, 32, word width of load/store data
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before abort (8-bit counter)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid34  in  1  stage-3/4 register holds a real instruction (0 = bubble)
- addp4out34  in  32  PC+4 of the instruction (link value for jumps)
- alu_out34  in  32  ALU result / memory byte address
- read_data234  in  32  store data (rs2 value)
- write_reg34  in  5  destination register
- memwrite34  in  1  store
- mem_read34  in  1  load
- wr_en34  in  1  register-file write enable
- memtoreg34  in  1  select load data for writeback
- jump34  in  1  select PC+4 for writeback
- stall34  out  1  hold the stage-3/4 register this cycle
- dmem_req  out  1  memory request valid
- dmem_we  out  1  request is a write
- dmem_addr  out  ADDR_W  word-aligned byte address
- dmem_wdata  out  DATA_W  store data
- dmem_ready  in  1  memory accepts the request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DATA_W  load data
- wb_valid45  out  1  writeback stage holds a result
- wb_data45  out  32  writeback value
- wb_reg45  out  5  writeback destination
- wb_en45  out  1  register-file write enable to writeback
- bus_err  out  1  sticky error flag (misalign or timeout), cleared only by reset

Behaviour:
- Reset (async, rst_n=0): state=IDLE. wb_valid45, wb_en45, dmem_req, dmem_we, bus_err = 0. wb_data45=0, wb_reg45=0, timeout counter=0. Reset mid-access abandons the request; dmem_req drops immediately.
- memop = valid34 & (mem_read34 | memwrite34).
- misalign = memop & (alu_out34[1:0] != 0).
- conflict = mem_read34 & memwrite34.
- States:
  - IDLE: no memop → register a result every cycle, stall34=0, 1-cycle latency.
  - IDLE, memop with misalign or conflict → no request issued. Set bus_err; register a result with wb_en45=0. Takes 1 cycle, no stall.
  - IDLE, clean memop → stall34=1 combinationally. Latch addr, wdata and we into dmem_* registers; go to REQ.
  - REQ: dmem_req=1, stall34=1. On dmem_ready: write → DONE; read → WAIT.
  - WAIT: dmem_req=0, stall34=1. On dmem_rvalid: capture dmem_rdata → DONE. dmem_rvalid seen in any other state is ignored.
  - DONE: stall34=0. Register the result (load data or store completion), then return to IDLE. The upstream register advances on this cycle.
- Timeout: the counter clears on entry to REQ and increments in REQ and WAIT. When it reaches TIMEOUT: set bus_err, load data forced to 0, wb_en45=0, go to DONE.
- Result mux, priority jump34 > memtoreg34 > ALU:
  - jump34 → addp4out34
  - memtoreg34 → load data
  - otherwise → alu_out34
- wb_en45 = wr_en34 & valid34 & no error for this instruction. A store never writes the register file.
- wb_valid45 = valid34 on every cycle a result is registered. It is 0 while stalled (bubble to writeback).
- Latency: non-memory op 1 cycle; store ≥3 cycles (IDLE→REQ→DONE); load ≥4 cycles (IDLE→REQ→WAIT→DONE). Each extra cycle of dmem_ready/dmem_rvalid delay adds one cycle.
- dmem_addr, dmem_wdata and dmem_we are stable from REQ entry until dmem_ready.

Decomposition:
- Shared package: state encoding (IDLE, REQ, WAIT, DONE), writeback-select encoding, ADDR_W/DATA_W defaults.
- One sub-module: mem_timeout_ctr (clear, enable, terminal-count flag, 8-bit).

Test Plan:
- ALU op, valid34=1, alu_out34=0x1234, wr_en34=1 → next cycle wb_data45=0x1234, wb_en45=1, stall34 never asserted.
- Load at 0x40, dmem_ready same cycle as req, rvalid next cycle with 0xDEADBEEF → stall34 high 3 cycles; wb_data45=0xDEADBEEF in cycle 4.
- Store at 0x80, wdata 0xA5A5A5A5, dmem_ready delayed 2 cycles → dmem_req held 3 cycles with stable addr/data; wb_en45=0.
- Load at 0x41 → no dmem_req, bus_err=1, wb_en45=0, no stall.
- Load with dmem_ready never asserted → bus_err after 255 cycles, stall34 released, wb_en45=0. Then rst_n low mid-REQ → dmem_req=0 and bus_err=0 immediately.
- jump34=1, addp4out34=0x104 → wb_data45=0x104.
